// File: rtl/dot_product_seq_pkg.sv
// Shared types and default widths for the dot_product_seq sequencer and its datapath.
package dot_product_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ACC_WIDTH  = 32;
  localparam int DEFAULT_LEN_WIDTH  = 16;

endpackage

// File: rtl/dot_product.sv
// Combinational N-lane signed dot product; each product is sign-extended to ACC_WIDTH and summed modulo 2^ACC_WIDTH.
module dot_product
  import dot_product_seq_pkg::*;
#(
  parameter int N          = 4,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH
) (
  input  logic [N*DATA_WIDTH-1:0] a,
  input  logic [N*DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]    y
);

  always_comb begin
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    sum;
    sum  = '0;
    prod = '0;
    for (int unsigned i = 0; i < N; i++) begin
      prod = $signed(a[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]) * $signed(b[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]);
      sum  = sum + ACC_WIDTH'(prod);
    end
    y = sum;
  end

endmodule

// File: rtl/dot_product_seq.sv
// Streams len chunks through one dot_product and accumulates a scalar result.
// Optional macro DOT_PRODUCT_SEQ_RELU_EN clamps a negative final result to zero.
module dot_product_seq
  import dot_product_seq_pkg::*;
#(
  parameter int N          = 4,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
  parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    len,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_a,
  input  logic [N*DATA_WIDTH-1:0] in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_WIDTH-1:0]    out_data
);

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [LEN_WIDTH-1:0] remaining;
  logic [ACC_WIDTH-1:0] dp;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [ACC_WIDTH-1:0] acc_final;

  dot_product #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_dp (
    .a (in_a),
    .b (in_b),
    .y (dp)
  );

  assign acc_next = acc + dp;

  // The clamp applies only on the last beat so out_data in DONE is never negative.
`ifdef DOT_PRODUCT_SEQ_RELU_EN
  assign acc_final = acc_next[ACC_WIDTH-1] ? '0 : acc_next;
`else
  assign acc_final = acc_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            if (len != '0) begin
              remaining <= len;
              state     <= RUN;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (in_valid) begin
            remaining <= remaining - 1'b1;
            if (remaining == LEN_WIDTH'(1)) begin
              acc   <= acc_final;
              state <= DONE;
            end else begin
              acc <= acc_next;
            end
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign in_ready  = (state == RUN);
  assign out_valid = (state == DONE);
  assign out_data  = acc;

endmodule

// File: doc/dot_product_seq.md
Name: dot_product_seq

Overview:
Sequencer that drives one combinational dot_product datapath over a long vector. A vector of len chunks, each N elements wide, is streamed in with a valid/ready handshake. Per-chunk dot products are accumulated in a registered accumulator, and one scalar result is returned on a valid/ready output. It sits between the operand-fetch logic (near-memory buffer reads) and the result writeback path.

Parameters:
N, 4, elements per chunk; this is the dot_product lane count.
DATA_WIDTH, 8, signed element width.
ACC_WIDTH, 32, signed accumulator/result width; must be at least 2*DATA_WIDTH.
LEN_WIDTH, 16, width of the chunk-count field.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  job start pulse; sampled only in IDLE.
len  in  LEN_WIDTH  number of chunks in the job; captured with start.
busy  out  1  high in RUN and DONE.
in_valid  in  1  chunk operands valid.
in_ready  out  1  sequencer accepts a chunk.
in_a  in  N*DATA_WIDTH  packed signed operand A; element i is at bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH].
in_b  in  N*DATA_WIDTH  packed signed operand B; same packing as in_a.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts result.
out_data  out  ACC_WIDTH  signed accumulated result.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, acc=0, remaining=0, busy=0, in_ready=0, out_valid=0, out_data=0. Asserting reset mid-job aborts the job immediately. No partial result is emitted.
- States are IDLE, RUN and DONE. All outputs are decoded from registered state: in_ready=(state==RUN), out_valid=(state==DONE), busy=(state!=IDLE).
- IDLE, start=1, len!=0: remaining<=len, acc<=0, go to RUN.
- IDLE, start=1, len==0: acc<=0, go directly to DONE. The result is 0 and no chunk is consumed.
- start is ignored in RUN and DONE. len is ignored except in the cycle start is accepted.
- RUN, accept beat (in_valid && in_ready):
  - acc<=acc+dp, where dp is the dot_product output for the current in_a/in_b.
  - remaining<=remaining-1.
  - If remaining==1 on that beat, go to DONE.
- RUN, no beat: acc and remaining hold. in_valid may toggle freely.
- Throughput is one chunk per cycle with in_valid held high.
- Latency: out_valid rises in the cycle after the last beat is accepted.
- Arithmetic:
  - Products are signed 2*DATA_WIDTH and sign-extended to ACC_WIDTH, as in dot_product.
  - Accumulation wraps modulo 2^ACC_WIDTH; no overflow flag.
- DONE: out_data=acc, held stable while out_valid=1 && out_ready=0. On out_ready=1, go to IDLE.
- There is a minimum of one IDLE cycle between jobs, so a start asserted in the out-handshake cycle is ignored.
- Back-to-back jobs: 1 + len + 1 cycles per job minimum (start, beats, DONE with out_ready high).

Optional Feature:
- Macro: DOT_PRODUCT_SEQ_RELU_EN.
- Defined: on DONE entry, a negative acc is clamped to 0, so out_data is never negative. A zero-length job still returns 0.
- Undefined: out_data is the raw signed accumulator.
- Handshake timing is identical in both builds.

Decomposition:
- Shared package dot_product_seq_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default width constants (DATA_WIDTH, ACC_WIDTH, LEN_WIDTH).
- One sub-module: the existing dot_product, instantiated once with matching N/DATA_WIDTH/ACC_WIDTH.
- Everything else (FSM, counter, accumulator) stays in dot_product_seq.

Test Plan:
- Single chunk: len=1, in_a={1,2,3,4}, in_b={5,6,7,8}, out_ready=1 -> out_valid one cycle after the beat, out_data=70, then IDLE.
- Multi-chunk with bubbles:
  - Stimulus: len=3, chunks (all 1s·all 2s), (all -1s·all 3s), (all 127s·all -128s); in_valid low every other cycle.
  - Response: out_data=8-12-65024=-65028.
  - acc holds during bubbles; exactly 3 beats are accepted.
- Zero length and ignored start: start with len=0 -> DONE next cycle, out_data=0, in_ready never rises. A start pulse during RUN of a len=2 job is ignored.
- Output backpressure: out_ready=0 for 5 cycles after completion -> out_valid and out_data stable, in_ready=0. out_ready=1 -> IDLE next cycle.
- Reset mid-job: len=4, rst_n low after 2 beats -> all outputs 0 immediately. Next job len=1 of {1,1,1,1}·{1,1,1,1} -> out_data=4.
- RELU build: len=1, {-1,-1,-1,-1}·{1,1,1,1} -> out_data=0 with DOT_PRODUCT_SEQ_RELU_EN defined, -4 without.
